mn_symbol_packer: RTL and testbench

- Downstream consumer of the two-input Mealy controller's per-cycle output pair {m,n}.
- Treats each sampled {m,n} as one 2-bit symbol and packs SYMS consecutive symbols into one word.
- Buffers completed words in a small first-word-fall-through (FWFT) FIFO, read out through a valid/ready handshake.
- Flags words lost to overflow and counts "11" symbols for debug.

---
 rtl/mn_symbol_packer_if.sv | 44 ++++
 rtl/mn_symbol_packer.sv | 161 ++++++++++++++++
 tb/tb_mn_symbol_packer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mn_symbol_packer_if.sv
// mn_symbol_packer_if: symbol-input / packed-word-output bundle for mn_symbol_packer.
// Latency: none (wires only). Backpressure: out_ready from the consumer; the symbol side has none.
// Ports: in_valid/m/n/flush (producer->packer), out_valid/out_data/out_ready (FWFT read side),
//        level/overflow/ones_cnt status; out_parity only when MN_PACKER_PARITY_EN is defined.
interface mn_symbol_packer_if #(
  parameter int SYMS  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int W  = 2 * SYMS;
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             m;
  logic             n;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LW-1:0]    level;
  logic             overflow;
  logic [CNT_W-1:0] ones_cnt;
`ifdef MN_PACKER_PARITY_EN
  logic             out_parity;
`endif

  // master: the side that produces symbols and consumes words
  modport master (
`ifdef MN_PACKER_PARITY_EN
    input  out_parity,
`endif
    output in_valid, m, n, flush, out_ready,
    input  out_valid, out_data, level, overflow, ones_cnt
  );

  // slave: the packer itself
  modport slave (
`ifdef MN_PACKER_PARITY_EN
    output out_parity,
`endif
    input  in_valid, m, n, flush, out_ready,
    output out_valid, out_data, level, overflow, ones_cnt
  );
endinterface

// File: rtl/mn_symbol_packer.sv
// mn_symbol_packer: packs SYMS {m,n} symbols (first symbol in the LSBs) into a word held in a DEPTH-entry FWFT FIFO.
// Latency: word visible on out_valid/out_data right after the edge that accepts its last symbol.
// Backpressure: none upstream; words completing into a full FIFO (without a same-cycle pop) are dropped and overflow sticks.
// Ports: clk, rst_b (async active-low), bus (mn_symbol_packer_if.slave).
// Optional macro MN_PACKER_PARITY_EN adds out_parity, stored per entry alongside the word.
module mn_symbol_packer #(
  parameter int SYMS  = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_b,
  mn_symbol_packer_if.slave   bus
);
  localparam int W  = 2 * SYMS;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SYMS);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [LW-1:0]    LVL_FULL  = LW'(DEPTH);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(SYMS - 1);

  typedef enum logic {ST_EMPTY, ST_PARTIAL} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_sym_cnt, w_sym_cnt_nxt;
  logic [W-1:0]     r_shift, w_shift_nxt;
  logic             w_push_req;
  logic [W-1:0]     w_push_word;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic [CNT_W-1:0] r_ones_cnt;

  logic             w_accept;
  logic [1:0]       w_sym;
  logic [W-1:0]     w_sym_placed;
  logic             w_out_valid;
  logic             w_pop;
  logic             w_push_ok;

  assign w_accept     = bus.in_valid & ~bus.flush;
  assign w_sym        = {bus.m, bus.n};
  // Symbol k lands at bits [2k+1:2k]; in EMPTY r_sym_cnt is 0, so this also covers the first symbol.
  assign w_sym_placed = {{(W-2){1'b0}}, w_sym} << {r_sym_cnt, 1'b0};

  assign w_out_valid  = (r_level != '0);
  assign w_pop        = w_out_valid & bus.out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
  assign w_push_ok    = w_push_req & ((r_level < LVL_FULL) | w_pop);

  // Assembler FSM: state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state   <= ST_EMPTY;
      r_sym_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sym_cnt <= w_sym_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Assembler FSM: next state and push request
  always_comb begin
    w_state_nxt   = r_state;
    w_sym_cnt_nxt = r_sym_cnt;
    w_shift_nxt   = r_shift;
    w_push_req    = 1'b0;
    w_push_word   = '0;
    if (bus.flush) begin
      w_state_nxt   = ST_EMPTY;
      w_sym_cnt_nxt = '0;
      w_shift_nxt   = '0;
    end else if (w_accept) begin
      case (r_state)
        ST_EMPTY: begin
          w_shift_nxt   = w_sym_placed;
          w_sym_cnt_nxt = CW'(1);
          w_state_nxt   = ST_PARTIAL;
        end
        ST_PARTIAL: begin
          if (r_sym_cnt == CNT_LAST) begin
            // Word complete: request the push whether or not the FIFO can take it.
            w_push_req    = 1'b1;
            w_push_word   = r_shift | w_sym_placed;
            w_shift_nxt   = '0;
            w_sym_cnt_nxt = '0;
            w_state_nxt   = ST_EMPTY;
          end else begin
            w_shift_nxt   = r_shift | w_sym_placed;
            w_sym_cnt_nxt = r_sym_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt   = ST_EMPTY;
          w_sym_cnt_nxt = '0;
          w_shift_nxt   = '0;
        end
      endcase
    end
  end

  // FWFT FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= w_push_word;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overflow (flush clears) and saturating "11" counter (reset only)
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_overflow <= 1'b0;
      r_ones_cnt <= '0;
    end else begin
      if (bus.flush)                    r_overflow <= 1'b0;
      else if (w_push_req & ~w_push_ok) r_overflow <= 1'b1;
      if (w_accept && (w_sym == 2'b11) && (r_ones_cnt != CNT_MAX))
        r_ones_cnt <= r_ones_cnt + CNT_W'(1);
    end
  end

`ifdef MN_PACKER_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (w_push_ok) begin
      r_par[r_wptr] <= ^w_push_word;
    end
  end

  assign bus.out_parity = w_out_valid ? r_par[r_rptr] : 1'b0;
`endif

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem[r_rptr] : '0;
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;
  assign bus.ones_cnt  = r_ones_cnt;
endmodule

// File: tb/tb_mn_symbol_packer.sv
// tb_mn_symbol_packer: randomized + directed bench for mn_symbol_packer with a queue-based reference model.
// Latency: model state is committed at each rising edge; the monitor compares on falling edges.
// Backpressure: out_ready is driven by the stimulus; the monitor pops the scoreboard on every accepted read.
module tb_mn_symbol_packer;
  localparam int SYMS  = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int W     = 2 * SYMS;
  localparam int OMAX  = (1 << CNT_W) - 1;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  bit   started;

  // Reference model: symbols collected so far, expected FIFO words, occupancy, flags
  int            part[$];
  logic [W-1:0]  exp_q[$];
  int            mlevel;
  bit            movf;
  int            mones;

  mn_symbol_packer_if #(.SYMS(SYMS), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  mn_symbol_packer #(.SYMS(SYMS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    part.delete();
    exp_q.delete();
    mlevel = 0;
    movf   = 1'b0;
    mones  = 0;
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit v, input bit [1:0] s, input bit f, input bit rdy);
    bit           pop;
    bit           push;
    int           lev0;
    logic [W-1:0] word;
    bus.in_valid  = v;
    bus.m         = s[1];
    bus.n         = s[0];
    bus.flush     = f;
    bus.out_ready = rdy;
    lev0 = mlevel;
    pop  = (lev0 > 0) && rdy;
    push = 1'b0;
    @(posedge clk);
    if (f) begin
      part.delete();
      movf = 1'b0;
    end else if (v) begin
      if (s == 2'b11 && mones < OMAX) mones++;
      part.push_back(int'(s));
      if (part.size() == SYMS) begin
        word = '0;
        for (int k = 0; k < SYMS; k++) word = word | (W'(part[k]) << (2 * k));
        part.delete();
        if (lev0 < DEPTH || pop) begin
          exp_q.push_back(word);
          push = 1'b1;
        end else begin
          movf = 1'b1;
        end
      end
    end
    mlevel = lev0 - int'(pop) + int'(push);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 1'b0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && mlevel > 0; i++) cycle(1'b0, 2'b00, 1'b0, 1'b1);
    check("drain_level", bus.level, 0);
  endtask

  task automatic put_word(input bit [1:0] s0, input bit [1:0] s1, input bit [1:0] s2,
                          input bit [1:0] s3, input bit rdy);
    cycle(1'b1, s0, 1'b0, rdy);
    cycle(1'b1, s1, 1'b0, rdy);
    cycle(1'b1, s2, 1'b0, rdy);
    cycle(1'b1, s3, 1'b0, rdy);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] w;
    if (started && rst_b) begin
      check("out_valid", bus.out_valid, (mlevel != 0));
      check("level", bus.level, mlevel);
      check("overflow", bus.overflow, movf);
      check("ones_cnt", bus.ones_cnt, mones);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: read of 0x%0h with no expected word at %0t", bus.out_data, $time);
        end else begin
          w = exp_q.pop_front();
          check("out_data", bus.out_data, w);
`ifdef MN_PACKER_PARITY_EN
          check("out_parity", bus.out_parity, ^w);
`endif
        end
      end else if (!bus.out_valid) begin
        check("out_data_empty", bus.out_data, 0);
`ifdef MN_PACKER_PARITY_EN
        check("out_parity_empty", bus.out_parity, 0);
`endif
      end
    end
  end

  initial begin
    bit v, f, rdy;
    bit [1:0] s;
    checks = 0;
    errors = 0;
    started = 1'b0;
    model_clear();
    rst_b = 1'b0;
    bus.in_valid = 1'b0; bus.m = 1'b0; bus.n = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_level", bus.level, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_ones_cnt", bus.ones_cnt, 0);
    #10 rst_b = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;

    // Back-to-back word 01,10,11,00
    put_word(2'b01, 2'b10, 2'b11, 2'b00, 1'b0);
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, 8'h39);
    check("t1_level", bus.level, 1);
    check("t1_ones", bus.ones_cnt, 1);
    drain();

    // Same word with 2-cycle gaps
    cycle(1'b1, 2'b01, 1'b0, 1'b0); idle(2, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0); idle(2, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0); idle(2, 1'b0);
    check("t2_not_yet", bus.out_valid, 0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    check("t2_data", bus.out_data, 8'h39);
    drain();

    // Five words into a 4-deep FIFO with no reads
    for (int i = 0; i < 5; i++) put_word(2'(i), 2'(i + 1), 2'(i + 2), 2'(i + 3), 1'b0);
    check("t3_level", bus.level, DEPTH);
    check("t3_overflow", bus.overflow, 1);
    drain();
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    check("t3_flush_ovf", bus.overflow, 0);

    // Full FIFO, last symbol coincides with a read
    for (int i = 0; i < DEPTH; i++) put_word(2'b10, 2'(i), 2'b01, 2'b11, 1'b0);
    put_word(2'b11, 2'b00, 2'b01, 2'b10, 1'b0);
    check("t4_dropped", bus.overflow, 1);
    cycle(1'b0, 2'b00, 1'b1, 1'b0);
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b1);
    check("t4_level", bus.level, DEPTH);
    check("t4_overflow", bus.overflow, 0);
    drain();

    // Flush mid-word with a symbol present, then 11 x4
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 1'b1, 1'b0);
    mones = mones; // flush leaves the counter alone
    put_word(2'b11, 2'b11, 2'b11, 2'b11, 1'b0);
    check("t5_data", bus.out_data, 8'hFF);
    check("t5_level", bus.level, 1);
    drain();

    // Async reset mid-word with level=2
    put_word(2'b01, 2'b01, 2'b01, 2'b01, 1'b0);
    put_word(2'b10, 2'b10, 2'b10, 2'b10, 1'b0);
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    check("t6_pre_level", bus.level, 2);
    #2;
    rst_b = 1'b0;
    model_clear();
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    #1;
    check("t6_valid", bus.out_valid, 0);
    check("t6_data", bus.out_data, 0);
    check("t6_level", bus.level, 0);
    check("t6_ones", bus.ones_cnt, 0);
    @(posedge clk); #3;
    rst_b = 1'b1;
    @(posedge clk); #1;
    put_word(2'b10, 2'b01, 2'b00, 2'b11, 1'b0);
    check("t6_fresh", bus.out_data, 8'hC6);
    check("t6_fresh_lvl", bus.level, 1);
    drain();

    // Random traffic with phases of heavy and light backpressure
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      s   = 2'($urandom_range(0, 3));
      f   = ($urandom_range(0, 49) == 0);
      rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      cycle(v, s, f, rdy);
    end
    drain();

    // Drive the "11" counter into saturation
    for (int i = 0; i < OMAX + 20; i++) cycle(1'b1, 2'b11, 1'b0, 1'b1);
    check("sat_ones", bus.ones_cnt, OMAX);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
